// File: rtl/gs_pkg.sv
// gs_pkg: shared types for the Gaussian-splatting tile scheduler.
// Record layout, record width and scheduler state encoding.
package gs_pkg;

  localparam int GS_INPUT_W = 32;
  localparam int GS_REC_W   = 7 * GS_INPUT_W;

  typedef struct packed {
    logic [GS_INPUT_W-1:0] a;
    logic [GS_INPUT_W-1:0] b;
    logic [GS_INPUT_W-1:0] c;
    logic [GS_INPUT_W-1:0] mu_x;
    logic [GS_INPUT_W-1:0] mu_y;
    logic [GS_INPUT_W-1:0] color;
    logic [GS_INPUT_W-1:0] opacity;
  } gs_rec_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_OUT = 2'd2,
    DONE     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/gs_rec_fifo.sv
// gs_rec_fifo: synchronous first-word-fall-through record FIFO.
// A push is visible at data_o one cycle later (registered write).
module gs_rec_fifo #(
  parameter int WIDTH = 224,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written on push, never reset (contents qualified by count).
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gs_tile_scheduler.sv
// gs_tile_scheduler: feeds gaussian_splatting_engine one tile at a time.
// Fetches the tile's records into a credit-controlled prefetch FIFO and
// streams them to the engine, then hands the finished tile to the consumer.
// Optional build macro GS_SCHED_PERF_EN adds perf_tiles / perf_stall_cycles.
//
//  state    | meaning
//  IDLE     | waiting for a tile descriptor (tile_ready=1)
//  RUN      | fetching records and streaming them to the engine
//  WAIT_OUT | all records sent; waiting for engine output + consumer
//  DONE     | empty tile reported (tile_done & tile_empty) until done_ready
module gs_tile_scheduler
  import gs_pkg::*;
#(
  parameter int INPUT_WIDTH = GS_INPUT_W,
  parameter int ADDR_WIDTH  = 16,
  parameter int CNT_WIDTH   = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tile_valid,
  output logic                     tile_ready,
  input  logic [INPUT_WIDTH-1:0]   tile_x,
  input  logic [INPUT_WIDTH-1:0]   tile_y,
  input  logic [ADDR_WIDTH-1:0]    tile_base,
  input  logic [CNT_WIDTH-1:0]     tile_count,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic                     mem_rsp_valid,
  input  logic [7*INPUT_WIDTH-1:0] mem_rsp_data,
  output logic                     eng_in_valid,
  input  logic                     eng_in_ready,
  output logic                     eng_end_of_tile,
  output logic [7*INPUT_WIDTH-1:0] eng_rec,
  output logic [INPUT_WIDTH-1:0]   eng_x,
  output logic [INPUT_WIDTH-1:0]   eng_y,
  input  logic                     eng_out_valid,
  output logic                     eng_out_ready,
  output logic                     tile_done,
  input  logic                     done_ready,
  output logic                     tile_empty
`ifdef GS_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_tiles,
  output logic [31:0]              perf_stall_cycles
`endif
);

  localparam int REC_W = 7 * INPUT_WIDTH;
  localparam int CRW   = $clog2(FIFO_DEPTH) + 1;

  sched_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [INPUT_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [CNT_WIDTH:0]      issued_q, issued_d, sent_q, sent_d;
  logic [CRW-1:0]          credits_q, credits_d;

  logic                    tile_hs, req_hs, eng_hs, last_rec;
  logic                    fifo_full, fifo_empty;
  logic [CRW-1:0]          fifo_count;
  logic [REC_W-1:0]        fifo_head;

  assign tile_hs  = tile_valid && tile_ready;
  assign req_hs   = mem_req_valid && mem_req_ready;
  assign eng_hs   = eng_in_valid && eng_in_ready;
  assign last_rec = ((sent_q + 1'b1) == {1'b0, count_q});

  gs_rec_fifo #(.WIDTH(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (mem_rsp_valid),
    .data_i  (mem_rsp_data),
    .pop_i   (eng_hs),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tile_valid) state_d = (tile_count == '0) ? DONE : RUN;
      RUN:      if (eng_hs && last_rec) state_d = WAIT_OUT;
      WAIT_OUT: if (eng_out_valid && done_ready) state_d = IDLE;
      DONE:     if (done_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode. tile_done is a valid held until done_ready; in WAIT_OUT it
  // follows the engine's out_valid so it coincides with the engine handshake.
  always_comb begin
    tile_ready    = 1'b0;
    mem_req_valid = 1'b0;
    eng_in_valid  = 1'b0;
    eng_out_ready = 1'b0;
    tile_done     = 1'b0;
    tile_empty    = 1'b0;
    case (state_q)
      IDLE: tile_ready = 1'b1;
      RUN: begin
        mem_req_valid = ({1'b0, count_q} > issued_q) && (credits_q != '0);
        eng_in_valid  = !fifo_empty;
      end
      WAIT_OUT: begin
        eng_out_ready = done_ready;
        tile_done     = eng_out_valid;
      end
      DONE: begin
        tile_done  = 1'b1;
        tile_empty = 1'b1;
      end
      default: ;
    endcase
  end

  assign eng_end_of_tile = eng_in_valid && last_rec;
  assign eng_rec         = eng_in_valid ? fifo_head : '0;
  assign mem_req_addr    = mem_req_valid ? (base_q + ADDR_WIDTH'(issued_q)) : '0;
  assign eng_x           = x_q;
  assign eng_y           = y_q;

  // Descriptor capture, issue/send counters and credit bookkeeping.
  always_comb begin
    base_d    = base_q;
    count_d   = count_q;
    x_d       = x_q;
    y_d       = y_q;
    issued_d  = issued_q;
    sent_d    = sent_q;
    credits_d = credits_q;
    if (tile_hs) begin
      base_d   = tile_base;
      count_d  = tile_count;
      x_d      = tile_x;
      y_d      = tile_y;
      issued_d = '0;
      sent_d   = '0;
    end else begin
      if (req_hs) issued_d = issued_q + 1'b1;
      if (eng_hs) sent_d   = sent_q + 1'b1;
    end
    if (req_hs && !eng_hs)      credits_d = credits_q - 1'b1;
    else if (!req_hs && eng_hs) credits_d = credits_q + 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      count_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      issued_q  <= '0;
      sent_q    <= '0;
      credits_q <= CRW'(FIFO_DEPTH);
    end else begin
      base_q    <= base_d;
      count_q   <= count_d;
      x_q       <= x_d;
      y_q       <= y_d;
      issued_q  <= issued_d;
      sent_q    <= sent_d;
      credits_q <= credits_d;
    end
  end

  // Credits bound outstanding requests to the FIFO depth, so a response can never find it full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) mem_rsp_valid |-> !fifo_full);
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CRW'(FIFO_DEPTH));

`ifdef GS_SCHED_PERF_EN
  logic [31:0] perf_tiles_q, perf_stall_q;

  // Saturating tile and stall counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_tiles_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (tile_done && done_ready && (perf_tiles_q != '1)) perf_tiles_q <= perf_tiles_q + 1'b1;
      if ((state_q == RUN) && fifo_empty && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_tiles        = perf_tiles_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_gs_tile_scheduler.sv
// tb_gs_tile_scheduler: scoreboard bench for gs_tile_scheduler.
// Stimulus pushes expected addresses/records/done flags; a monitor pops and
// compares on every DUT handshake. Honours GS_SCHED_PERF_EN when defined.
module tb_gs_tile_scheduler;
  import gs_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  tile_valid, tile_ready;
  logic [31:0]           tile_x, tile_y;
  logic [15:0]           tile_base;
  logic [11:0]           tile_count;
  logic                  mem_req_valid, mem_req_ready;
  logic [15:0]           mem_req_addr;
  logic                  mem_rsp_valid;
  logic [GS_REC_W-1:0]   mem_rsp_data;
  logic                  eng_in_valid, eng_in_ready, eng_end_of_tile;
  logic [GS_REC_W-1:0]   eng_rec;
  logic [31:0]           eng_x, eng_y;
  logic                  eng_out_valid, eng_out_ready;
  logic                  tile_done, done_ready, tile_empty;
`ifdef GS_SCHED_PERF_EN
  logic [31:0]           perf_tiles, perf_stall_cycles;
`endif

  gs_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y), .tile_base(tile_base), .tile_count(tile_count),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
    .eng_end_of_tile(eng_end_of_tile), .eng_rec(eng_rec),
    .eng_x(eng_x), .eng_y(eng_y),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
    .tile_done(tile_done), .done_ready(done_ready), .tile_empty(tile_empty)
`ifdef GS_SCHED_PERF_EN
    , .perf_tiles(perf_tiles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    gs_rec_t     rec;
    logic        eot;
    logic [31:0] x;
    logic [31:0] y;
  } exp_t;

  exp_t        exp_rec[$];
  logic [15:0] exp_addr[$];
  logic        exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_req    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic gs_rec_t rec_of(input logic [15:0] a);
    gs_rec_t r;
    r.a = {16'hA0A0, a};  r.b = {16'hB1B1, a};  r.c = {16'hC2C2, a};
    r.mu_x = {16'hD3D3, a}; r.mu_y = {16'hE4E4, a};
    r.color = {16'h5F5F, a}; r.opacity = {16'h6A6A, a};
    return r;
  endfunction

  // Memory (1-cycle latency) and engine out_valid models.
  initial begin : models
    logic rq, eot_hs, out_hs;
    logic [15:0] ra;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    eng_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      rq     = rst_n && mem_req_valid && mem_req_ready;
      ra     = mem_req_addr;
      eot_hs = rst_n && eng_in_valid && eng_in_ready && eng_end_of_tile;
      out_hs = rst_n && eng_out_valid && eng_out_ready;
      @(posedge clk); #1;
      mem_rsp_valid = rq;
      mem_rsp_data  = rq ? rec_of(ra) : '0;
      if (!rst_n || out_hs) eng_out_valid = 1'b0;
      else if (eot_hs)      eng_out_valid = 1'b1;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req_valid && mem_req_ready) begin
          n_req++;
          chk("req expected", exp_addr.size() != 0, 1'b1);
          if (exp_addr.size() != 0) chk("req addr", mem_req_addr, exp_addr.pop_front());
        end
        if (eng_in_valid && eng_in_ready) begin
          chk("rec expected", exp_rec.size() != 0, 1'b1);
          if (exp_rec.size() != 0) begin
            e = exp_rec.pop_front();
            chk("eng_rec", eng_rec, e.rec);
            chk("end_of_tile", eng_end_of_tile, e.eot);
            chk("eng_x", eng_x, e.x);
            chk("eng_y", eng_y, e.y);
          end
        end
        if (tile_done && done_ready) begin
          chk("done expected", exp_done.size() != 0, 1'b1);
          if (exp_done.size() != 0) chk("tile_empty", tile_empty, exp_done.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_tile(input logic [31:0] x, input logic [31:0] y,
                           input logic [15:0] base, input logic [11:0] cnt);
    exp_t e;
    logic acc;
    for (int i = 0; i < int'(cnt); i++) begin
      e.rec = rec_of(base + 16'(i));
      e.eot = (i == int'(cnt) - 1);
      e.x   = x;
      e.y   = y;
      exp_rec.push_back(e);
      exp_addr.push_back(base + 16'(i));
    end
    exp_done.push_back(cnt == 12'd0);
    tile_x = x; tile_y = y; tile_base = base; tile_count = cnt;
    tile_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = tile_ready;
    end
    chk("tile accepted", acc, 1'b1);
    @(posedge clk); #1;
    tile_valid = 1'b0;
  endtask

  // Counts negedges until the tile_done handshake; -1 on timeout.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (tile_done && done_ready) n = i;
    end
    chk("done before timeout", n > 0, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, r0, bad, held, trdy;
    rst_n = 1'b0; tile_valid = 1'b0; tile_x = '0; tile_y = '0;
    tile_base = '0; tile_count = '0; mem_req_ready = 1'b1;
    eng_in_ready = 1'b1; done_ready = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("reset tile_ready", tile_ready, 1'b1);
    chk("reset outputs", {mem_req_valid, eng_in_valid, eng_end_of_tile, eng_out_ready,
                          tile_done, tile_empty}, 6'b0);
    chk("reset eng_x/y", {eng_x, eng_y}, 64'h0);
`ifdef GS_SCHED_PERF_EN
    chk("reset perf_tiles", perf_tiles, 32'd0);
`endif

    // 1: single record
    send_tile(32'h0000_0100, 32'h0000_0200, 16'h0010, 12'd1);
    wait_done(40, n);
    chk("t1 latency", n, 4);

    // 2: engine stalled 5 cycles, count 4
    eng_in_ready = 1'b0;
    r0 = n_req;
    send_tile(32'h0000_0300, 32'h0000_0400, 16'h0020, 12'd4);
    cyc(5);
    chk("t2 reqs during stall", n_req - r0, 4);
    chk("t2 in_valid held", eng_in_valid, 1'b1);
    eng_in_ready = 1'b1;
    wait_done(40, n);

    // 3: empty tile
    send_tile(32'h0000_0500, 32'h0000_0600, 16'h0077, 12'd0);
    wait_done(40, n);
    chk("t3 done next cycle", n, 1);

    // 4: address wrap
    send_tile(32'h0000_0700, 32'h0000_0800, 16'hFFFE, 12'd3);
    wait_done(40, n);
    chk("t4 latency", n, 6);

    // 5: consumer stalls in WAIT_OUT
    done_ready = 1'b0;
    send_tile(32'h0000_0900, 32'h0000_0A00, 16'h0030, 12'd2);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      @(negedge clk);
      if (tile_done) n = i;
    end
    chk("t5 reached WAIT_OUT", n > 0, 1'b1);
    @(posedge clk); #1;
    bad = 0; held = 0; trdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (eng_out_ready !== 1'b0) bad++;
      if (tile_done === 1'b1) held++;
      if (tile_ready !== 1'b0) trdy++;
    end
    @(posedge clk); #1;
    chk("t5 eng_out_ready low", bad, 0);
    chk("t5 tile_done held", held, 10);
    chk("t5 tile_ready low", trdy, 0);
    done_ready = 1'b1;
    wait_done(10, n);
    chk("t5 release", n, 1);
`ifdef GS_SCHED_PERF_EN
    chk("perf_tiles before reset", perf_tiles, 32'd5);
`endif

    // 6: reset mid-run of count 8, credits limit outstanding requests
    eng_in_ready = 1'b0;
    r0 = n_req;
    send_tile(32'h0000_0B00, 32'h0000_0C00, 16'h0040, 12'd8);
    cyc(7);
    chk("t6 credit limit", n_req - r0, 4);
    chk("t6 req stalled", mem_req_valid, 1'b0);
    rst_n = 1'b0;
    exp_rec.delete(); exp_addr.delete(); exp_done.delete();
    eng_in_ready = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    chk("t6 tile_ready", tile_ready, 1'b1);
    chk("t6 outputs cleared", {mem_req_valid, eng_in_valid, eng_end_of_tile, eng_out_ready,
                               tile_done, tile_empty}, 6'b0);
    chk("t6 eng_x cleared", eng_x, 32'h0);
    chk("t6 eng_rec cleared", eng_rec, '0);
`ifdef GS_SCHED_PERF_EN
    chk("perf_tiles after reset", perf_tiles, 32'd0);
`endif
    send_tile(32'h0000_0D00, 32'h0000_0E00, 16'h0050, 12'd3);
    wait_done(40, n);
    chk("t6 clean tile latency", n, 6);
`ifdef GS_SCHED_PERF_EN
    chk("perf_tiles after tile", perf_tiles, 32'd1);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd2);
`endif

    cyc(3);
    chk("addr queue drained", exp_addr.size(), 0);
    chk("rec queue drained", exp_rec.size(), 0);
    chk("done queue drained", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
